crs_arbiter_n: RTL and testbench

Parametrised command/response/status arbiter granting N peripheral ports access to the system register bus (y), with single write, single read and buffered burst-write transactions. It is the generalised successor of the fixed four-port CRS master and sits between the UART/command decoders and the register file. It adds:
- round-robin arbitration that skips idle ports;
- a configurable read wait;
- a burst-length cap;
- a stall-safe priority override.

---
 rtl/crs_arbiter_n.sv | 191 +++++++++++++++++++
 tb/tb_crs_arbiter_n.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crs_arbiter_n.sv
// rtl/crs_arbiter_n.sv - N-port round-robin command/response/status arbiter for the register bus
// Optional feature macro: CRS_ARB_TIMEOUT_EN (forced release of a port that never drops its request).
module crs_arbiter_n #(
    parameter int N_PORTS     = 4,
    parameter int ADR_W       = 12,
    parameter int DATA_W      = 16,
    parameter int RD_WAIT     = 1,
    parameter int MAX_BURST   = 0,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic [ADR_W-1:0]                   y_adr,
    output logic [DATA_W-1:0]                  y_wr_data,
    input  logic [DATA_W-1:0]                  y_rd_data,
    output logic                               y_wr,
    input  logic                               po_en,
    input  logic                               po_wr,
    input  logic [ADR_W-1:0]                   po_adr,
    input  logic [DATA_W-1:0]                  po_wr_data,
    output logic [DATA_W-1:0]                  po_rd_data,
    input  logic [N_PORTS-1:0]                 p_wr_req,
    input  logic [N_PORTS-1:0]                 p_bwr_req,
    input  logic [N_PORTS-1:0]                 p_rd_req,
    output logic [N_PORTS-1:0]                 p_ack,
    input  logic [N_PORTS*ADR_W-1:0]           p_adr,
    input  logic [N_PORTS*DATA_W-1:0]          p_wr_data,
    output logic [DATA_W-1:0]                  p_rd_data,
    output logic [N_PORTS-1:0]                 p_buf_rd,
    input  logic [N_PORTS-1:0]                 p_buf_empty,
    input  logic [N_PORTS*(ADR_W+DATA_W)-1:0]  p_buf_wr_data,
    output logic [$clog2(N_PORTS)-1:0]         grant,
    output logic                               err_timeout
);
    localparam int PW = $clog2(N_PORTS);
    localparam int FW = ADR_W + DATA_W;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_WAIT   = 3'd1;
    localparam logic [2:0] S_BWR_CHK   = 3'd2;
    localparam logic [2:0] S_BWR_WAIT  = 3'd3;
    localparam logic [2:0] S_BWR_WRITE = 3'd4;
    localparam logic [2:0] S_ACK       = 3'd5;

    logic [2:0]         fsm;
    logic [PW-1:0]      rr_ptr;
    logic [PW-1:0]      grant_r;
    logic [ADR_W-1:0]   adr_r;
    logic [DATA_W-1:0]  wr_data_r;
    logic [DATA_W-1:0]  rd_data_r;
    logic               wr_r;
    logic [3:0]         wait_cnt;
    logic [15:0]        word_cnt;

    logic [N_PORTS-1:0] req_any;
    logic [N_PORTS-1:0] req_v;
    logic [N_PORTS-1:0] grant_oh;
    logic               sel_found;
    logic [PW-1:0]      sel_idx;
    logic [PW-1:0]      idx;
    logic               grant_req;
    logic               burst_done;
    logic               fire_timeout;
    logic [FW-1:0]      buf_word;
    logic [PW-1:0]      next_ptr;

    assign req_any    = p_wr_req | p_bwr_req | p_rd_req;
    assign grant_oh   = {{(N_PORTS-1){1'b0}}, 1'b1} << grant_r;
    assign grant_req  = req_any[grant_r];
    assign buf_word   = p_buf_wr_data[grant_r*FW +: FW];
    assign burst_done = p_buf_empty[grant_r] ||
                        ((MAX_BURST != 0) && (word_cnt == 16'(MAX_BURST)));
    assign next_ptr   = (grant_r == PW'(N_PORTS-1)) ? '0 : grant_r + 1'b1;

    // Round-robin search upward from rr_ptr with wrap; lowest offset wins.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        idx       = rr_ptr;
        for (int i = 0; i < N_PORTS; i++) begin
            if (!sel_found && req_v[idx]) begin
                sel_found = 1'b1;
                sel_idx   = idx;
            end
            idx = (idx == PW'(N_PORTS-1)) ? '0 : idx + 1'b1;
        end
    end

`ifdef CRS_ARB_TIMEOUT_EN
    logic [15:0]        to_cnt;
    logic [N_PORTS-1:0] stale;
    logic               err_r;

    // A port released by timeout stays masked until its request drops.
    assign req_v        = req_any & ~stale;
    assign fire_timeout = !po_en && (fsm == S_ACK) && grant_req &&
                          (to_cnt == 16'(ACK_TIMEOUT-1));
    assign err_timeout  = err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            to_cnt <= '0;
            stale  <= '0;
            err_r  <= 1'b0;
        end else begin
            err_r <= fire_timeout;
            if (!po_en) begin
                stale  <= (stale & req_any) | (fire_timeout ? grant_oh : '0);
                to_cnt <= ((fsm == S_ACK) && !fire_timeout) ? to_cnt + 16'd1 : '0;
            end
        end
    end
`else
    logic unused_ack_timeout;

    assign unused_ack_timeout = ^32'(ACK_TIMEOUT);
    assign req_v        = req_any;
    assign fire_timeout = 1'b0;
    assign err_timeout  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm       <= S_IDLE;
            rr_ptr    <= '0;
            grant_r   <= '0;
            adr_r     <= '0;
            wr_data_r <= '0;
            rd_data_r <= '0;
            wr_r      <= 1'b0;
            wait_cnt  <= '0;
            word_cnt  <= '0;
        end else if (!po_en) begin
            wr_r <= 1'b0;
            case (fsm)
                S_IDLE: begin
                    if (sel_found) begin
                        grant_r <= sel_idx;
                        adr_r   <= p_adr[sel_idx*ADR_W +: ADR_W];
                        if (p_wr_req[sel_idx]) begin
                            wr_data_r <= p_wr_data[sel_idx*DATA_W +: DATA_W];
                            wr_r      <= 1'b1;
                            fsm       <= S_ACK;
                        end else if (p_bwr_req[sel_idx]) begin
                            word_cnt <= '0;
                            fsm      <= S_BWR_CHK;
                        end else begin
                            wait_cnt <= '0;
                            fsm      <= S_RD_WAIT;
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (wait_cnt == 4'(RD_WAIT-1)) begin
                        rd_data_r <= y_rd_data;
                        fsm       <= S_ACK;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_BWR_CHK:   fsm <= burst_done ? S_ACK : S_BWR_WAIT;
                S_BWR_WAIT:  fsm <= S_BWR_WRITE;
                S_BWR_WRITE: begin
                    adr_r     <= buf_word[DATA_W +: ADR_W];
                    wr_data_r <= buf_word[DATA_W-1:0];
                    wr_r      <= 1'b1;
                    word_cnt  <= word_cnt + 16'd1;
                    fsm       <= S_BWR_CHK;
                end
                S_ACK: begin
                    if (!grant_req || fire_timeout) begin
                        fsm    <= S_IDLE;
                        rr_ptr <= next_ptr;
                    end
                end
                default: fsm <= S_IDLE;
            endcase
        end
    end

    // Override owns the bus while po_en is high; a held internal write appears once it drops.
    assign y_adr      = po_en ? po_adr     : adr_r;
    assign y_wr_data  = po_en ? po_wr_data : wr_data_r;
    assign y_wr       = po_en ? po_wr      : wr_r;
    assign po_rd_data = y_rd_data;
    assign p_rd_data  = rd_data_r;
    assign grant      = grant_r;
    assign p_ack      = (fsm == S_ACK) ? grant_oh : '0;
    assign p_buf_rd   = ((fsm == S_BWR_CHK) && !burst_done && !po_en) ? grant_oh : '0;

endmodule

// File: tb/tb_crs_arbiter_n.sv
// tb/tb_crs_arbiter_n.sv - directed self-checking bench for crs_arbiter_n
module tb_crs_arbiter_n;
    localparam int NP = 4;
    localparam int AW = 12;
    localparam int DW = 16;
    localparam int FW = AW + DW;

    logic              clk = 1'b0;
    logic              rst;
    logic [AW-1:0]     y_adr;
    logic [DW-1:0]     y_wr_data;
    logic [DW-1:0]     y_rd_data;
    logic              y_wr;
    logic              po_en;
    logic              po_wr;
    logic [AW-1:0]     po_adr;
    logic [DW-1:0]     po_wr_data;
    logic [DW-1:0]     po_rd_data;
    logic [NP-1:0]     p_wr_req;
    logic [NP-1:0]     p_bwr_req;
    logic [NP-1:0]     p_rd_req;
    logic [NP-1:0]     p_ack;
    logic [NP*AW-1:0]  p_adr;
    logic [NP*DW-1:0]  p_wr_data;
    logic [DW-1:0]     p_rd_data;
    logic [NP-1:0]     p_buf_rd;
    logic [NP-1:0]     p_buf_empty;
    logic [NP*FW-1:0]  p_buf_wr_data;
    logic [1:0]        grant;
    logic              err_timeout;

    int vec  = 0;
    int errs = 0;

    always #5 clk = ~clk;

    crs_arbiter_n #(
        .N_PORTS(NP), .ADR_W(AW), .DATA_W(DW), .RD_WAIT(3), .MAX_BURST(2), .ACK_TIMEOUT(8)
    ) dut (
        .clk(clk), .rst(rst),
        .y_adr(y_adr), .y_wr_data(y_wr_data), .y_rd_data(y_rd_data), .y_wr(y_wr),
        .po_en(po_en), .po_wr(po_wr), .po_adr(po_adr), .po_wr_data(po_wr_data),
        .po_rd_data(po_rd_data),
        .p_wr_req(p_wr_req), .p_bwr_req(p_bwr_req), .p_rd_req(p_rd_req), .p_ack(p_ack),
        .p_adr(p_adr), .p_wr_data(p_wr_data), .p_rd_data(p_rd_data),
        .p_buf_rd(p_buf_rd), .p_buf_empty(p_buf_empty), .p_buf_wr_data(p_buf_wr_data),
        .grant(grant), .err_timeout(err_timeout)
    );

    // Port-0 FIFO: output word registered one cycle after the read pulse.
    logic [FW-1:0] fifo_mem [0:15];
    int            fifo_wcnt = 0;
    int            fifo_rptr = 0;
    logic [FW-1:0] fifo_dout = '0;
    logic          fifo_empty;

    assign fifo_empty    = (fifo_rptr == fifo_wcnt);
    assign p_buf_empty   = {3'b111, fifo_empty};
    assign p_buf_wr_data = {{(3*FW){1'b0}}, fifo_dout};

    always @(posedge clk) begin
        if (p_buf_rd[0]) begin
            fifo_dout <= fifo_mem[fifo_rptr[3:0]];
            fifo_rptr <= fifo_rptr + 1;
        end
    end

    int            cyc = 0;
    logic [FW-1:0] wlog [0:63];
    int            wcyc [0:63];
    int            wn = 0;
    int            stall_rd = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (y_wr && !po_en && wn < 64) begin
            wlog[wn[5:0]] <= {y_adr, y_wr_data};
            wcyc[wn[5:0]] <= cyc;
            wn <= wn + 1;
        end
        if (po_en && p_buf_rd != '0) stall_rd <= stall_rd + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic set_port(input int k, input logic [AW-1:0] a, input logic [DW-1:0] d);
        p_adr[k*AW +: AW]     = a;
        p_wr_data[k*DW +: DW] = d;
    endtask

    task automatic push_word(input logic [FW-1:0] w);
        fifo_mem[fifo_wcnt[3:0]] = w;
        fifo_wcnt = fifo_wcnt + 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        set_port(1, 12'h0AA, 16'h1111);
        p_wr_req = 4'b0010;
        tick();
        tick();
        vec++; if (y_wr !== 1'b0)       begin errs++; $display("FAIL reset_y_wr got %0b want 0", y_wr); end
        vec++; if (p_ack !== 4'b0)      begin errs++; $display("FAIL reset_p_ack got %b want 0000", p_ack); end
        vec++; if (grant !== 2'd0)      begin errs++; $display("FAIL reset_grant got %0d want 0", grant); end
        vec++; if (y_adr !== 12'h0)     begin errs++; $display("FAIL reset_y_adr got %h want 000", y_adr); end
        vec++; if (p_rd_data !== 16'h0) begin errs++; $display("FAIL reset_p_rd_data got %h want 0000", p_rd_data); end
        vec++; if (p_buf_rd !== 4'b0)   begin errs++; $display("FAIL reset_p_buf_rd got %b want 0000", p_buf_rd); end
        vec++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL reset_err got %0b want 0", err_timeout); end
        rst = 1'b0;
        tick();
        vec++; if (y_wr !== 1'b1)       begin errs++; $display("FAIL post_reset_y_wr got %0b want 1", y_wr); end
        vec++; if (grant !== 2'd1)      begin errs++; $display("FAIL post_reset_grant got %0d want 1", grant); end
        vec++; if (p_ack !== 4'b0010)   begin errs++; $display("FAIL post_reset_ack got %b want 0010", p_ack); end
        vec++; if (y_adr !== 12'h0AA)   begin errs++; $display("FAIL post_reset_adr got %h want 0aa", y_adr); end
        p_wr_req = '0;
        tick();
        vec++; if (p_ack !== 4'b0)      begin errs++; $display("FAIL post_reset_release got %b want 0000", p_ack); end
    endtask

    task automatic test_write();
        set_port(2, 12'h123, 16'hBEEF);
        p_wr_req = 4'b0100;
        tick();
        vec++; if (y_wr !== 1'b1)         begin errs++; $display("FAIL wr_y_wr got %0b want 1", y_wr); end
        vec++; if (y_adr !== 12'h123)     begin errs++; $display("FAIL wr_y_adr got %h want 123", y_adr); end
        vec++; if (y_wr_data !== 16'hBEEF) begin errs++; $display("FAIL wr_y_wr_data got %h want beef", y_wr_data); end
        vec++; if (p_ack !== 4'b0100)     begin errs++; $display("FAIL wr_p_ack got %b want 0100", p_ack); end
        vec++; if (grant !== 2'd2)        begin errs++; $display("FAIL wr_grant got %0d want 2", grant); end
        p_wr_req = '0;
        tick();
        vec++; if (y_wr !== 1'b0)         begin errs++; $display("FAIL wr_single_pulse got %0b want 0", y_wr); end
        vec++; if (p_ack !== 4'b0)        begin errs++; $display("FAIL wr_ack_drop got %b want 0000", p_ack); end
    endtask

    task automatic test_round_robin();
        logic [1:0]    seq [0:3];
        int            n = 0;
        logic [NP-1:0] ack_or = '0;
        logic [1:0]    exp_g;
        do_reset();
        set_port(0, 12'h010, 16'h0A0A);
        set_port(3, 12'h030, 16'h0B0B);
        p_wr_req = 4'b1001;
        for (int c = 0; c < 40 && n < 4; c++) begin
            tick();
            if (p_ack != '0) begin
                seq[n] = grant;
                n++;
            end
            ack_or   = ack_or | p_ack;
            p_wr_req = 4'b1001 & ~p_ack;
        end
        p_wr_req = '0;
        tick();
        tick();
        vec++; if (n !== 4) begin errs++; $display("FAIL rr_grant_count got %0d want 4", n); end
        for (int i = 0; i < 4 && i < n; i++) begin
            exp_g = (i % 2 == 0) ? 2'd0 : 2'd3;
            vec++; if (seq[i] !== exp_g) begin errs++; $display("FAIL rr_seq[%0d] got %0d want %0d", i, seq[i], exp_g); end
        end
        vec++; if (ack_or[2:1] !== 2'b00) begin errs++; $display("FAIL rr_idle_ports_acked got %b want 00", ack_or[2:1]); end
    endtask

    task automatic test_read();
        int            ports [0:1] = '{1, 3};
        logic [AW-1:0] adrs  [0:1] = '{12'h321, 12'h07E};
        logic [DW-1:0] dats  [0:1] = '{16'h5A5A, 16'hC3A5};
        logic [NP-1:0] oh;
        int            lat;
        for (int t = 0; t < 2; t++) begin
            set_port(ports[t], adrs[t], 16'h0);
            oh        = 4'b0001 << ports[t];
            y_rd_data = dats[t];
            p_rd_req  = oh;
            lat       = 0;
            for (int c = 1; c <= 10; c++) begin
                tick();
                if (p_ack != '0) begin
                    lat = c;
                    break;
                end
            end
            vec++; if (lat !== 4)            begin errs++; $display("FAIL rd%0d_latency got %0d want 4", t, lat); end
            vec++; if (p_ack !== oh)         begin errs++; $display("FAIL rd%0d_ack got %b want %b", t, p_ack, oh); end
            vec++; if (p_rd_data !== dats[t]) begin errs++; $display("FAIL rd%0d_data got %h want %h", t, p_rd_data, dats[t]); end
            vec++; if (y_adr !== adrs[t])    begin errs++; $display("FAIL rd%0d_adr got %h want %h", t, y_adr, adrs[t]); end
            vec++; if (po_rd_data !== dats[t]) begin errs++; $display("FAIL rd%0d_po_rd_data got %h want %h", t, po_rd_data, dats[t]); end
            p_rd_req  = '0;
            y_rd_data = '0;
            tick();
        end
    endtask

    task automatic test_burst_cap();
        int            w0;
        int            c0;
        int            lat;
        logic [FW-1:0] w [0:2];
        for (int i = 0; i < 3; i++) begin
            w[i] = {12'h101 + 12'(i), 16'h1001 + 16'(i)};
            push_word(w[i]);
        end
        set_port(0, 12'h0F0, 16'h0);
        w0 = wn;
        c0 = cyc;
        p_bwr_req = 4'b0001;
        lat = 0;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (p_ack[0]) begin
                lat = c;
                break;
            end
        end
        vec++; if (lat !== 8)      begin errs++; $display("FAIL burst_ack_cycle got %0d want 8", lat); end
        vec++; if (wn - w0 !== 2)  begin errs++; $display("FAIL burst_cap_writes got %0d want 2", wn - w0); end
        vec++; if (wcyc[6'(w0)] - c0 !== 4) begin errs++; $display("FAIL burst_first_wr_cycle got %0d want 4", wcyc[6'(w0)] - c0); end
        vec++; if (wlog[6'(w0)] !== w[0])   begin errs++; $display("FAIL burst_word0 got %h want %h", wlog[6'(w0)], w[0]); end
        vec++; if (wlog[6'(w0+1)] !== w[1]) begin errs++; $display("FAIL burst_word1 got %h want %h", wlog[6'(w0+1)], w[1]); end
        vec++; if (fifo_empty !== 1'b0)     begin errs++; $display("FAIL burst_fifo_left got %0b want 0", fifo_empty); end
        p_bwr_req = '0;
        tick();
        p_bwr_req = 4'b0001;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (p_ack[0]) break;
        end
        p_bwr_req = '0;
        tick();
        vec++; if (wn - w0 !== 3)           begin errs++; $display("FAIL burst_flush_writes got %0d want 3", wn - w0); end
        vec++; if (wlog[6'(w0+2)] !== w[2]) begin errs++; $display("FAIL burst_word2 got %h want %h", wlog[6'(w0+2)], w[2]); end
        vec++; if (fifo_empty !== 1'b1)     begin errs++; $display("FAIL burst_fifo_drained got %0b want 1", fifo_empty); end
    endtask

    task automatic test_stall();
        int            w0;
        int            s0;
        int            done = 0;
        logic [FW-1:0] w [0:2];
        for (int i = 0; i < 3; i++) begin
            w[i] = {12'h201 + 12'(i), 16'h2001 + 16'(i)};
            push_word(w[i]);
        end
        w0 = wn;
        s0 = stall_rd;
        p_bwr_req = 4'b0001;
        for (int i = 0; i < 4; i++) tick();
        po_en      = 1'b1;
        po_wr      = 1'b1;
        po_adr     = 12'hFFF;
        po_wr_data = 16'hCAFE;
        #1;
        vec++; if (y_wr !== 1'b1)          begin errs++; $display("FAIL stall_po_wr got %0b want 1", y_wr); end
        vec++; if (y_adr !== 12'hFFF)      begin errs++; $display("FAIL stall_po_adr got %h want fff", y_adr); end
        vec++; if (y_wr_data !== 16'hCAFE) begin errs++; $display("FAIL stall_po_data got %h want cafe", y_wr_data); end
        vec++; if (p_buf_rd !== 4'b0)      begin errs++; $display("FAIL stall_buf_rd got %b want 0000", p_buf_rd); end
        po_wr = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        tick();
        po_en = 1'b0;
        #1;
        vec++; if (y_wr !== 1'b1)      begin errs++; $display("FAIL stall_held_wr got %0b want 1", y_wr); end
        vec++; if ({y_adr, y_wr_data} !== w[0]) begin errs++; $display("FAIL stall_held_word got %h want %h", {y_adr, y_wr_data}, w[0]); end
        for (int c = 0; c < 60; c++) begin
            tick();
            if (p_ack[0]) begin
                p_bwr_req = '0;
                if (fifo_empty) begin
                    done = 1;
                    break;
                end
            end else begin
                p_bwr_req = 4'b0001;
            end
        end
        p_bwr_req = '0;
        tick();
        vec++; if (done !== 1)         begin errs++; $display("FAIL stall_drain_timeout got %0d want 1", done); end
        vec++; if (wn - w0 !== 3)      begin errs++; $display("FAIL stall_write_count got %0d want 3", wn - w0); end
        for (int i = 0; i < 3 && i < wn - w0; i++) begin
            vec++; if (wlog[6'(w0+i)] !== w[i]) begin errs++; $display("FAIL stall_word%0d got %h want %h", i, wlog[6'(w0+i)], w[i]); end
        end
        vec++; if (stall_rd - s0 !== 0) begin errs++; $display("FAIL stall_buf_rd_count got %0d want 0", stall_rd - s0); end
    endtask

    task automatic test_timeout();
        int seen = 0;
        int ok = 0;
        set_port(1, 12'h055, 16'h0055);
        set_port(2, 12'h066, 16'h0066);
`ifdef CRS_ARB_TIMEOUT_EN
        p_wr_req = 4'b0010;
        tick();
        p_wr_req = 4'b0110;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (err_timeout) begin
                seen = 1;
                break;
            end
        end
        vec++; if (seen !== 1) begin errs++; $display("FAIL to_err_pulse got %0d want 1", seen); end
        for (int c = 0; c < 2; c++) begin
            tick();
            if (c == 0) begin
                vec++; if (err_timeout !== 1'b0) begin errs++; $display("FAIL to_err_width got %0b want 0", err_timeout); end
            end
            if (p_ack == 4'b0100) begin
                ok = 1;
                break;
            end
        end
        vec++; if (ok !== 1) begin errs++; $display("FAIL to_next_grant got %b want 0100", p_ack); end
        p_wr_req = 4'b0010;
        for (int c = 0; c < 4; c++) tick();
        vec++; if (p_ack !== 4'b0) begin errs++; $display("FAIL to_stale_ignored got %b want 0000", p_ack); end
`else
        p_wr_req = 4'b0010;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (err_timeout) seen = 1;
        end
        vec++; if (seen !== 0)        begin errs++; $display("FAIL no_to_err got %0d want 0", seen); end
        vec++; if (p_ack !== 4'b0010) begin errs++; $display("FAIL no_to_ack_held got %b want 0010", p_ack); end
        ok = 1;
`endif
        p_wr_req = '0;
        tick();
        tick();
    endtask

    initial begin
        rst        = 1'b1;
        y_rd_data  = '0;
        po_en      = 1'b0;
        po_wr      = 1'b0;
        po_adr     = '0;
        po_wr_data = '0;
        p_wr_req   = '0;
        p_bwr_req  = '0;
        p_rd_req   = '0;
        p_adr      = '0;
        p_wr_data  = '0;
        test_reset();
        test_write();
        test_round_robin();
        test_read();
        test_burst_cap();
        test_stall();
        test_timeout();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule
